// File: rtl/vlog_lexer_pkg.sv
// Shared types and constants for the Verilog-subset tokenizer.
// Token kinds match the encoding the parser front end expects on tok_kind.
package vlog_lexer_pkg;

  typedef enum logic [2:0] {
    TK_EOF      = 3'd0,
    TK_IDENT    = 3'd1,
    TK_SYSIDENT = 3'd2,
    TK_NUMBER   = 3'd3,
    TK_PUNCT    = 3'd4,
    TK_OP2      = 3'd5,
    TK_ERROR    = 3'd6
  } tok_kind_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDENT,
    S_NUM,
    S_OP,
    S_SLASH,
    S_COMMENT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [7:0] CH_NL         = 8'h0a;
  localparam logic [7:0] CH_SLASH      = 8'h2f;
  localparam logic [7:0] CH_DOLLAR     = 8'h24;
  localparam logic [7:0] CH_UNDERSCORE = 8'h5f;
  localparam logic [7:0] CH_EQ         = 8'h3d;
  localparam logic [7:0] CH_BANG       = 8'h21;
  localparam logic [7:0] HASH_MUL      = 8'd31;

  // Characters that may begin a two-character operator: < > = ! * + - & |
  function automatic logic is_op_start(input logic [7:0] c);
    return (c == 8'h3c) || (c == 8'h3e) || (c == CH_EQ) || (c == CH_BANG) ||
           (c == 8'h2a) || (c == 8'h2b) || (c == 8'h2d) || (c == 8'h26) ||
           (c == 8'h7c);
  endfunction

endpackage

// File: rtl/vlog_char_class.sv
// Purely combinational character classifier plus two-character operator matcher.
module vlog_char_class
  import vlog_lexer_pkg::*;
(
  input  logic [7:0] ch,
  input  logic [7:0] first,
  output logic       ws,
  output logic       id_start,
  output logic       id_cont,
  output logic       digit,
  output logic       op_start,
  output logic       printable,
  output logic       pair_ok
);
  logic alpha;

  assign alpha     = ((ch >= 8'h41) && (ch <= 8'h5a)) || ((ch >= 8'h61) && (ch <= 8'h7a));
  assign ws        = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0d) || (ch == CH_NL);
  assign digit     = (ch >= 8'h30) && (ch <= 8'h39);
  assign id_start  = alpha || (ch == CH_UNDERSCORE);
  assign id_cont   = id_start || digit || (ch == CH_DOLLAR);
  assign op_start  = is_op_start(ch);
  assign printable = (ch >= 8'h21) && (ch <= 8'h7e);

  // Doubled operators (<< >> == ** ++ -- && ||) or '='-suffixed ones (<= >= == !=)
  assign pair_ok = ((ch == first) && (first != CH_BANG) && is_op_start(first)) ||
                   ((ch == CH_EQ) && ((first == 8'h3c) || (first == 8'h3e) ||
                                      (first == CH_EQ) || (first == CH_BANG)));

endmodule

// File: rtl/vlog_lexer.sv
// Streaming Verilog-subset tokenizer: one character per cycle in, classified tokens out.
// Terminators are never consumed by the token they end; they are re-presented in IDLE.
module vlog_lexer
  import vlog_lexer_pkg::*;
#(
  parameter int NUM_W  = 32,
  parameter int LEN_W  = 5,
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [2:0]        tok_kind,
  output logic [NUM_W-1:0]  tok_value,
  output logic [LEN_W-1:0]  tok_len,
  output logic [LINE_W-1:0] tok_line
);
  state_t              state_reg, state_next;
  tok_kind_t           kind_reg, kind_next;
  logic [NUM_W-1:0]    value_reg, value_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [LINE_W-1:0]   tline_reg, tline_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic                eof_reg, eof_next;
  logic                fire, eof_load;
  logic                cc_ws, cc_id_start, cc_id_cont, cc_digit, cc_op_start, cc_printable, cc_pair_ok;
  logic [LEN_W-1:0]    len_inc;
  logic [NUM_W-1:0]    hash_step, num_step;

  vlog_char_class u_class (
    .ch        (in_char),
    .first     (value_reg[7:0]),
    .ws        (cc_ws),
    .id_start  (cc_id_start),
    .id_cont   (cc_id_cont),
    .digit     (cc_digit),
    .op_start  (cc_op_start),
    .printable (cc_printable),
    .pair_ok   (cc_pair_ok)
  );

  assign len_inc   = (len_reg == {LEN_W{1'b1}}) ? len_reg : len_reg + LEN_W'(1);
  assign hash_step = value_reg * NUM_W'(HASH_MUL) + NUM_W'(in_char);
  assign num_step  = value_reg * NUM_W'(10) + NUM_W'(in_char - 8'h30);

  assign tok_valid = (state_reg == S_EMIT);
  assign tok_kind  = kind_reg;
  assign tok_value = value_reg;
  assign tok_len   = len_reg;
  assign tok_line  = tline_reg;

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    value_next = value_reg;
    len_next   = len_reg;
    tline_next = tline_reg;
    line_next  = line_reg;
    eof_next   = eof_reg;
    eof_load   = 1'b0;

    case (state_reg)
      S_IDLE:    in_ready = 1'b1;
      S_IDENT:   in_ready = cc_id_cont;
      S_NUM:     in_ready = cc_digit || (in_char == CH_UNDERSCORE);
      S_OP:      in_ready = cc_pair_ok;
      S_SLASH:   in_ready = (in_char == CH_SLASH);
      S_COMMENT: in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;

    fire = in_valid && in_ready;
    if (fire && (in_char == CH_NL)) line_next = line_reg + LINE_W'(1);
    if (fire && in_last) eof_next = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (fire) begin
          if (cc_ws) begin
            if (in_last) begin
              eof_load   = 1'b1;
              state_next = S_EMIT;
            end
          end else begin
            tline_next = line_reg;
            len_next   = LEN_W'(1);
            value_next = NUM_W'(in_char);
            kind_next  = TK_PUNCT;
            state_next = S_EMIT;
            if (cc_id_start) begin
              kind_next = TK_IDENT;
              if (!in_last) state_next = S_IDENT;
            end else if (in_char == CH_DOLLAR) begin
              kind_next  = TK_SYSIDENT;
              value_next = '0;
              if (!in_last) state_next = S_IDENT;
            end else if (cc_digit) begin
              kind_next  = TK_NUMBER;
              value_next = NUM_W'(in_char - 8'h30);
              if (!in_last) state_next = S_NUM;
            end else if (in_char == CH_SLASH) begin
              if (!in_last) state_next = S_SLASH;
            end else if (cc_op_start) begin
              if (!in_last) state_next = S_OP;
            end else if (!cc_printable) begin
              kind_next = TK_ERROR;
            end
          end
        end
      end
      S_IDENT: begin
        if (in_valid) begin
          if (cc_id_cont) begin
            value_next = hash_step;
            len_next   = len_inc;
            if (in_last) state_next = S_EMIT;
          end else begin
            state_next = S_EMIT;
          end
        end
      end
      S_NUM: begin
        if (in_valid) begin
          if (cc_digit || (in_char == CH_UNDERSCORE)) begin
            if (cc_digit) value_next = num_step;
            len_next = len_inc;
            if (in_last) state_next = S_EMIT;
          end else begin
            state_next = S_EMIT;
          end
        end
      end
      S_OP: begin
        if (in_valid) begin
          state_next = S_EMIT;
          if (cc_pair_ok) begin
            kind_next  = TK_OP2;
            value_next = NUM_W'({value_reg[7:0], in_char});
            len_next   = LEN_W'(2);
          end
        end
      end
      S_SLASH: begin
        if (in_valid) begin
          if (in_char == CH_SLASH) begin
            if (in_last) begin
              eof_load   = 1'b1;
              state_next = S_EMIT;
            end else begin
              state_next = S_COMMENT;
            end
          end else begin
            state_next = S_EMIT;
          end
        end
      end
      S_COMMENT: begin
        if (fire) begin
          if (in_last) begin
            eof_load   = 1'b1;
            state_next = S_EMIT;
          end else if (in_char == CH_NL) begin
            state_next = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (tok_ready) begin
          if (kind_reg == TK_EOF) state_next = S_DONE;
          else if (eof_reg)       eof_load   = 1'b1;
          else                    state_next = S_IDLE;
        end
      end
      default: ;
    endcase

    // EOF token carries the line count including any newline consumed this cycle
    if (eof_load) begin
      kind_next  = TK_EOF;
      value_next = '0;
      len_next   = '0;
      tline_next = line_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      kind_reg  <= TK_EOF;
      value_reg <= '0;
      len_reg   <= '0;
      tline_reg <= LINE_W'(1);
      line_reg  <= LINE_W'(1);
      eof_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      value_reg <= value_next;
      len_reg   <= len_next;
      tline_reg <= tline_next;
      line_reg  <= line_next;
      eof_reg   <= eof_next;
    end
  end

endmodule
